// File: rtl/mem_access_unit.sv
// mem_access_unit: Avalon-MM master executing one MIPS load/store per request
module mem_access_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rt_old,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} state_t;
    localparam logic [3:0] OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LW = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5, OP_LWR = 4'd6, OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10;
    localparam logic [7:0] LAST = 8'(READ_LATENCY > 0 ? READ_LATENCY - 1 : 0);

    state_t      state, state_n;
    logic [3:0]  op_q;
    logic [1:0]  b_q, b_in;
    logic [31:0] rt_q, wd_in;
    logic [3:0]  be_in;
    logic [7:0]  cnt;
    logic        legal, aligned, ok;

    // Select the loaded bytes for the latched op and merge LWL/LWR with rt
    function automatic logic [31:0] extract(input logic [3:0] o, input logic [1:0] b,
                                            input logic [31:0] w, input logic [31:0] rt);
        logic [31:0] s;
        s = w >> {b, 3'b000};
        return (o == OP_LB)  ? {{24{s[7]}}, s[7:0]} :
               (o == OP_LBU) ? {24'b0, s[7:0]} :
               (o == OP_LH)  ? {{16{s[15]}}, s[15:0]} :
               (o == OP_LHU) ? {16'b0, s[15:0]} :
               (o == OP_LWL) ? (w << {~b, 3'b000}) | (rt & ~(32'hFFFFFFFF << {~b, 3'b000})) :
               (o == OP_LWR) ? s | (rt & ~(32'hFFFFFFFF >> {b, 3'b000})) : w;
    endfunction

    // Decode the incoming request: legality, alignment, lane enables and replicated store data
    always_comb begin
        b_in    = addr[1:0];
        legal   = (op <= OP_LWR) || (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        aligned = (op == OP_LH || op == OP_LHU || op == OP_SH) ? !b_in[0] :
                  (op == OP_LW || op == OP_SW) ? (b_in == 2'd0) : 1'b1;
        ok      = legal && aligned;
        be_in   = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 4'b0001 << b_in :
                  (op == OP_LH || op == OP_LHU || op == OP_SH) ? 4'b0011 << b_in :
                  (op == OP_LWL) ? 4'b1111 >> (2'd3 - b_in) :
                  (op == OP_LWR) ? 4'b1111 << b_in : 4'b1111;
        wd_in   = (op == OP_SB) ? {4{wdata[7:0]}} : (op == OP_SH) ? {2{wdata[15:0]}} : wdata;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    // Next-state logic; stores finish at acceptance, loads after the read latency
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (start) state_n = ok ? REQ : DONE;
            REQ:       if (!waitrequest) state_n = (op_q[3] || READ_LATENCY == 0) ? DONE : WAIT_DATA;
            WAIT_DATA: if (cnt == LAST) state_n = DONE;
            default:   state_n = IDLE;
        endcase
    end

    // Status outputs follow the state directly
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Registered bus outputs, request latches, latency counter and result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= '0;
            b_q        <= '0;
            rt_q       <= '0;
            cnt        <= '0;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= '0;
            writedata  <= '0;
            fault      <= 1'b0;
            rdata      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q <= op;
                    b_q  <= b_in;
                    rt_q <= rt_old;
                    if (ok) begin
                        address    <= {addr[31:2], 2'b00};
                        byteenable <= be_in;
                        writedata  <= wd_in;
                        read       <= !op[3];
                        write      <= op[3];
                    end else fault <= 1'b1;
                end
                REQ: if (!waitrequest) begin
                    read  <= 1'b0;
                    write <= 1'b0;
                    cnt   <= '0;
                    if (op_q[3] || READ_LATENCY == 0) fault <= 1'b0;
                    if (!op_q[3] && READ_LATENCY == 0) rdata <= extract(op_q, b_q, readdata, rt_q);
                end
                WAIT_DATA: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == LAST) begin
                        fault <= 1'b0;
                        rdata <= extract(op_q, b_q, readdata, rt_q);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector bench with a latency-1 Avalon slave model
module tb_mem_access_unit;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] addr = '0, wdata = '0, rt_old = '0;
    logic        busy, done, fault, read, write, waitrequest;
    logic [31:0] rdata, address, writedata;
    logic [31:0] readdata = '0;
    logic [3:0]  byteenable;

    logic [31:0] mem [4] = '{32'h80FF7F01, 32'h0, 32'h0, 32'h0};
    int wait_n = 0, wcnt = 0;
    int rd_cyc = 0, wr_cyc = 0, both_cnt = 0, done_cnt = 0, unstable = 0;
    logic        prev_str = 1'b0;
    logic [67:0] prev_bus = '0;
    logic [31:0] obs_addr = '0, obs_wd = '0;
    logic [3:0]  obs_be = '0;
    int errors = 0, checks = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, wd, rt;
        int          wn;
        logic [31:0] exp_rd;
        logic        exp_f;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdat;
        string       name;
    } vec_t;
    vec_t vecs[$];

    mem_access_unit #(.READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
        .rt_old(rt_old), .busy(busy), .done(done), .rdata(rdata), .fault(fault),
        .address(address), .read(read), .write(write), .byteenable(byteenable),
        .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;

    assign waitrequest = (read || write) && (wcnt < wait_n);

    // Slave: stall wait_n cycles, merge writes by lane, return read word one edge later
    always @(posedge clk) begin
        if ((read || write) && !waitrequest) begin
            wcnt <= 0;
            if (read) readdata <= mem[address[3:2]];
            else for (int i = 0; i < 4; i++)
                if (byteenable[i]) mem[address[3:2]][8*i +: 8] <= writedata[8*i +: 8];
        end else if (read || write) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    // Bus monitor sampled mid-cycle
    always @(negedge clk) begin
        if (read) rd_cyc++;
        if (write) wr_cyc++;
        if (read && write) both_cnt++;
        if (done) done_cnt++;
        if ((read || write) && prev_str && {address, byteenable, writedata} !== prev_bus) unstable++;
        prev_str = read || write;
        prev_bus = {address, byteenable, writedata};
        if (read || write) begin
            obs_addr = address;
            obs_be   = byteenable;
            obs_wd   = writedata;
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run(input vec_t v);
        int rd0, wr0, cyc, exp_str;
        rd0 = rd_cyc;
        wr0 = wr_cyc;
        wait_n = v.wn;
        op = v.op; addr = v.a; wdata = v.wd; rt_old = v.rt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        exp_str = v.exp_f ? 0 : 1 + v.wn;
        chk({v.name, "_latency"}, cyc, v.exp_f ? 0 : v.op[3] ? 1 + v.wn : 2 + v.wn);
        chk({v.name, "_fault"}, {31'b0, fault}, {31'b0, v.exp_f});
        chk({v.name, "_rdata"}, rdata, v.exp_rd);
        chk({v.name, "_read_cycles"}, rd_cyc - rd0, v.op[3] ? 0 : exp_str);
        chk({v.name, "_write_cycles"}, wr_cyc - wr0, v.op[3] ? exp_str : 0);
        if (!v.exp_f) begin
            chk({v.name, "_byteenable"}, {28'b0, obs_be}, {28'b0, v.exp_be});
            chk({v.name, "_address"}, obs_addr, {v.a[31:2], 2'b00});
            if (v.op[3]) chk({v.name, "_writedata"}, obs_wd, v.exp_wdat);
        end
        @(negedge clk);
        chk({v.name, "_done_one_cycle"}, {31'b0, done}, 32'h0);
    endtask

    initial begin
        int cyc, dn0, wr0;
        vecs.push_back('{4'd0,  32'hBFC00003, 32'h0, 32'h0, 0, 32'hFFFFFF80, 1'b0, 4'b1000, 32'h0, "lb"});
        vecs.push_back('{4'd1,  32'hBFC00003, 32'h0, 32'h0, 0, 32'h00000080, 1'b0, 4'b1000, 32'h0, "lbu"});
        vecs.push_back('{4'd2,  32'hBFC00002, 32'h0, 32'h0, 0, 32'hFFFF80FF, 1'b0, 4'b1100, 32'h0, "lh"});
        vecs.push_back('{4'd3,  32'hBFC00002, 32'h0, 32'h0, 0, 32'h000080FF, 1'b0, 4'b1100, 32'h0, "lhu"});
        vecs.push_back('{4'd4,  32'hBFC00000, 32'h0, 32'h0, 3, 32'h80FF7F01, 1'b0, 4'b1111, 32'h0, "lw_wait3"});
        vecs.push_back('{4'd5,  32'hBFC00001, 32'h0, 32'hAABBCCDD, 0, 32'h7F01CCDD, 1'b0, 4'b0011, 32'h0, "lwl_b1"});
        vecs.push_back('{4'd6,  32'hBFC00001, 32'h0, 32'hAABBCCDD, 0, 32'hAA80FF7F, 1'b0, 4'b1110, 32'h0, "lwr_b1"});
        vecs.push_back('{4'd9,  32'hBFC00002, 32'h00001234, 32'h0, 0, 32'hAA80FF7F, 1'b0, 4'b1100, 32'h12341234, "sh"});
        vecs.push_back('{4'd4,  32'hBFC00000, 32'h0, 32'h0, 0, 32'h12347F01, 1'b0, 4'b1111, 32'h0, "lw_after_sh"});
        vecs.push_back('{4'd8,  32'hBFC00001, 32'h000000AB, 32'h0, 0, 32'h12347F01, 1'b0, 4'b0010, 32'hABABABAB, "sb"});
        vecs.push_back('{4'd0,  32'hBFC00001, 32'h0, 32'h0, 0, 32'hFFFFFFAB, 1'b0, 4'b0010, 32'h0, "lb_after_sb"});
        vecs.push_back('{4'd4,  32'hBFC00002, 32'h0, 32'h0, 0, 32'hFFFFFFAB, 1'b1, 4'b0000, 32'h0, "lw_misaligned"});
        vecs.push_back('{4'd7,  32'hBFC00000, 32'h0, 32'h0, 0, 32'hFFFFFFAB, 1'b1, 4'b0000, 32'h0, "illegal_op7"});
        vecs.push_back('{4'd10, 32'hBFC00004, 32'hDEADBEEF, 32'h0, 1, 32'hFFFFFFAB, 1'b0, 4'b1111, 32'hDEADBEEF, "sw_wait1"});
        vecs.push_back('{4'd4,  32'hBFC00004, 32'h0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0, "lw_word1"});
        vecs.push_back('{4'd2,  32'hBFC00001, 32'h0, 32'h0, 0, 32'hDEADBEEF, 1'b1, 4'b0000, 32'h0, "lh_misaligned"});
        vecs.push_back('{4'd5,  32'hBFC00000, 32'h0, 32'h11223344, 0, 32'h01223344, 1'b0, 4'b0001, 32'h0, "lwl_b0"});
        vecs.push_back('{4'd6,  32'hBFC00003, 32'h0, 32'h11223344, 0, 32'h11223312, 1'b0, 4'b1000, 32'h0, "lwr_b3"});

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_state", {read, write, busy, done, fault, byteenable}, 32'h0);
        chk("reset_bus", address | writedata | rdata, 32'h0);

        foreach (vecs[i]) run(vecs[i]);

        // Start held high while busy with a store request: must be ignored
        wr0 = wr_cyc;
        dn0 = done_cnt;
        wait_n = 2;
        op = 4'd4; addr = 32'hBFC00000; start = 1'b1;
        @(negedge clk);
        op = 4'd10; addr = 32'hBFC00004; wdata = 32'h0;
        wait_done(cyc);
        start = 1'b0;
        chk("busy_ignore_latency", cyc, 4);
        chk("busy_ignore_rdata", rdata, 32'h1234AB01);
        @(negedge clk);
        chk("busy_ignore_no_write", wr_cyc - wr0, 0);
        chk("busy_ignore_one_done", done_cnt - dn0, 1);
        run('{4'd4, 32'hBFC00004, 32'h0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0, "lw_word1_kept"});

        // Asynchronous reset while read is stalled
        wait_n = 5;
        op = 4'd4; addr = 32'hBFC00000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_read_before", {31'b0, read}, 32'h1);
        dn0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        chk("abort_read_drop", {31'b0, read}, 32'h0);
        chk("abort_busy_drop", {31'b0, busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_done", done_cnt - dn0, 0);
        run('{4'd4, 32'hBFC00000, 32'h0, 32'h0, 0, 32'h1234AB01, 1'b0, 4'b1111, 32'h0, "lw_after_abort"});

        chk("strobes_stable", unstable, 0);
        chk("read_write_exclusive", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
